// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Holds the FSM state encoding and the default operand/counter widths.
package div_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_step_counter.sv
// Loadable down-counter that tracks the remaining quotient steps.
// A load takes priority over a decrement; zero_flag reports an empty count.
module div_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             decrement,
  output logic [CNT_W-1:0] count,
  output logic             zero_flag
);

  // NOTE: sequential state is always written with <= so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement) begin
      count <= count - 1'b1;
    end
  end

  assign zero_flag = (count == '0);

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// launched by start and finished with a one-cycle done pulse.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state, state_next;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] count;
  logic             zero_flag;
  logic             accept_div;
  logic             last_step;

  logic [2*WIDTH:0] aq_shl;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;

  assign accept_div = (state == ST_IDLE) && start && (divisor != '0);
  assign last_step  = (state == ST_RUN) && (count == CNT_W'(1));

  div_step_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_div),
    .load_value (CNT_W'(WIDTH)),
    .decrement  ((state == ST_RUN) && !zero_flag),
    .count      (count),
    .zero_flag  (zero_flag)
  );

  // One restoring step: shift {A,Q}, try subtracting M, keep the result if non-negative.
  assign aq_shl  = {a, q} << 1;
  assign a_shift = aq_shl[2*WIDTH:WIDTH];
  assign trial   = a_shift - {1'b0, m};
  assign a_next  = trial[WIDTH] ? a_shift : trial;
  assign q_next  = aq_shl[WIDTH-1:0] | WIDTH'(!trial[WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (divisor != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && divisor != '0) begin
            a           <= '0;
            q           <= dividend;
            m           <= divisor;
            div_by_zero <= 1'b0;
          end else if (start) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        ST_RUN: begin
          a <= a_next;
          q <= q_next;
          if (last_step) begin
            quotient  <= q_next;
            remainder <= a_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and randomized operands against plain integer division.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.WIDTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int d;
    int exp_q;
    int exp_r;
    int exp_dbz;
    int exp_lat;
    int exp_busy;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch one division, wait (bounded) for done; returns with done high at a negedge.
  task automatic run_op(input int n, input int d, output int lat, output int busy_cycles);
    @(negedge clk);
    check("done_width", int'(done), 0);
    start    = 1'b1;
    dividend = 8'(n);
    divisor  = 8'(d);
    @(negedge clk);
    start       = 1'b0;
    lat         = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bc, pulses, stray;
    int n, d;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

    vecs.push_back('{100, 7, 14, 2, 0, 9, 8});
    vecs.push_back('{255, 1, 255, 0, 0, 9, 8});
    vecs.push_back('{5, 9, 0, 5, 0, 9, 8});
    vecs.push_back('{37, 0, 255, 37, 1, 1, 0});
    vecs.push_back('{37, 37, 1, 0, 0, 9, 8});
    vecs.push_back('{0, 5, 0, 0, 0, 9, 8});
    vecs.push_back('{255, 255, 1, 0, 0, 9, 8});
    vecs.push_back('{254, 255, 0, 254, 0, 9, 8});
    vecs.push_back('{128, 2, 64, 0, 0, 9, 8});

    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, lat, bc);
      check($sformatf("v%0d_quotient", i), int'(quotient), vecs[i].exp_q);
      check($sformatf("v%0d_remainder", i), int'(remainder), vecs[i].exp_r);
      check($sformatf("v%0d_dbz", i), int'(div_by_zero), vecs[i].exp_dbz);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
    end

    // Start pulsed mid-run with new operands must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 40) begin
      if (lat == 3) begin start = 1'b1; dividend = 8'd9; divisor = 8'd9; end
      if (lat == 4) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("ign_latency", lat, 9);
    check("ign_quotient", int'(quotient), 66);
    check("ign_remainder", int'(remainder), 2);
    pulses = done ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ign_done_pulses", pulses, 1);

    // Reset in the 4th RUN cycle aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 8'd250; divisor = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) stray++;
    end
    check("abort_no_done", stray, 0);
    run_op(250, 4, lat, bc);
    check("after_abort_quotient", int'(quotient), 62);
    check("after_abort_remainder", int'(remainder), 2);

    // Randomized operands against integer division and the division identity.
    for (int k = 0; k < 1000; k++) begin
      n = int'($urandom_range(0, 255));
      d = int'($urandom_range(1, 255));
      run_op(n, d, lat, bc);
      check("rnd_quotient", int'(quotient), n / d);
      check("rnd_remainder", int'(remainder), n % d);
      check("rnd_identity", int'(quotient) * d + int'(remainder), n);
      check("rnd_rem_lt_div", int'(int'(remainder) < d), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Sequential restoring unsigned divider. It is the division counterpart to the sequential Booth multiplier and sits beside it in the datapath as an iterative arithmetic unit.
- One quotient bit is resolved per clock, under a 3-state FSM and a loadable down-counter.
- A start/done handshake lets an external controller launch one division and collect the quotient and remainder.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits.
- CNT_W, 4, step-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  launch request; sampled only in IDLE.
- dividend  in  WIDTH  unsigned dividend; latched on accepted start.
- divisor  in  WIDTH  unsigned divisor; latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  registered quotient; held until next completion.
- remainder  out  WIDTH  registered remainder; held until next completion.
- div_by_zero  out  1  registered; set with done when divisor was 0, cleared on next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, A=0, Q=0, M=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Reset mid-RUN aborts with no done pulse.
- Internal registers:
  - A: accumulator, WIDTH+1 bits, signed test on the MSB.
  - Q: dividend/quotient shift register, WIDTH bits.
  - M: divisor, WIDTH bits.
  - count: CNT_W bits.
- IDLE:
  - If start=1 and divisor!=0: Q<=dividend, M<=divisor, A<=0, count<=WIDTH, div_by_zero<=0, go to RUN.
  - If start=1 and divisor==0: quotient<=all ones, remainder<=dividend, div_by_zero<=1, go to DONE.
- RUN, each edge performs one step:
  - Shift {A,Q} left by 1.
  - T = A_shifted - {0,M}, computed in WIDTH+1 bits.
  - If T[WIDTH]==1 (negative): keep A_shifted, Q[0]<=0. Otherwise: A<=T, Q[0]<=1.
  - count<=count-1.
  - On the edge where count goes 1→0: quotient<=new Q, remainder<=new A[WIDTH-1:0], go to DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- busy and done are decoded from the state register (Moore): busy=(state==RUN), done=(state==DONE).
- Latency:
  - Normal: start sampled at edge E0; steps on E1..E_WIDTH; done high in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after the start edge.
  - Divide-by-zero: done high in the cycle immediately after E0.
- start asserted in RUN or DONE is ignored (not queued). Changes to dividend/divisor after acceptance have no effect.
- Back-to-back operation: the earliest next start is the cycle after DONE, while in IDLE.
- The counter never underflows; decrement is gated at count==0.
- Invariant: quotient*divisor+remainder==dividend and remainder<divisor, for all divisor!=0.

Decomposition:
- Shared package (div_pkg):
  - State encoding, 2-bit: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH and CNT_W constants.
- Sub-module div_step_counter:
  - Loadable CNT_W-bit down-counter with load, load_value, decrement, count and a zero_flag output.
  - Priority: load > decrement.
  - The FSM uses zero_flag (or count==1 with decrement) to exit RUN.

Test Plan:
- 100/7: start=1 for one cycle → busy high for 8 cycles, done pulses 9 cycles after the start edge, quotient=14, remainder=2, div_by_zero=0.
- 255/1 then 5/9, back-to-back (second start in the first IDLE after done) → q=255,r=0, then q=0,r=5; both done pulses exactly 1 cycle wide.
- 37/0 → done the cycle after start, quotient=8'hFF, remainder=37, div_by_zero=1; a following 37/37 gives q=1, r=0, div_by_zero=0.
- Start with 200/3 (expect q=66, r=2), then pulse start with 9/9 on the 3rd RUN cycle and change the operand inputs to 9/9 for the rest of the run → ignored; result remains q=66, r=2 with a single done pulse.
- Start 250/4, assert rst during the 4th RUN cycle → immediately busy=0, quotient=0, remainder=0; no done pulse; a fresh 250/4 afterwards yields q=62, r=2.
- Randomized: 1000 random dividend/divisor pairs (divisor!=0) → every result satisfies q*d+r==n and r<d.
